// File: rtl/ysyx_23060240_ifu_if.sv
// Handshake/bus bundle for the instruction fetch unit.
// master: the IFU side; slave: PC stage, memory and decode side.
interface ysyx_23060240_ifu_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              pc_valid;
    logic              pc_ready;
    logic [ADDR_W-1:0] pc_in;
    logic              flush;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_data;
    logic              mem_rsp_err;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              fetch_err;

    modport master (
        input  pc_valid, pc_in, flush, mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_err, inst_ready,
        output pc_ready, mem_req_valid, mem_req_addr,
        output inst_valid, inst, inst_pc, fetch_err
    );

    modport slave (
        output pc_valid, pc_in, flush, mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_err, inst_ready,
        input  pc_ready, mem_req_valid, mem_req_addr,
        input  inst_valid, inst, inst_pc, fetch_err
    );
endinterface

// File: rtl/ysyx_23060240_ifu.sv
// Instruction fetch unit: takes a PC, issues one word read over a
// valid/ready memory port, holds the returned word for decode.
// One request outstanding; flush discards held or in-flight fetches.
// Optional macro IFU_ALIGN_CHK_EN: misaligned PCs skip memory and
// return fetch_err=1 with inst=0 and the exact PC.
module ysyx_23060240_ifu #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    ysyx_23060240_ifu_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              err_q, err_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              stale_q, stale_d;
    logic              launch;
    logic [ADDR_W-1:0] launch_pc;
    logic              rsp_live;
    logic              tmo;

    // A response owed to a timed-out request is swallowed once (stale).
    assign rsp_live = bus.mem_rsp_valid & ~stale_q;
    assign tmo      = (state_q == S_WAIT) & ~rsp_live & (cnt_q == TMO_LAST);

    assign bus.pc_ready      = (state_q == S_IDLE)
                             | ((state_q == S_HOLD) & bus.inst_ready)
                             | bus.flush;
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.inst_valid    = (state_q == S_HOLD);
    assign bus.inst          = inst_q;
    assign bus.inst_pc       = inst_pc_q;
    assign bus.fetch_err     = err_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            pc_q         <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            err_q        <= 1'b0;
            drop_q       <= 1'b0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
            stale_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            err_q        <= err_d;
            drop_q       <= drop_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
            stale_q      <= stale_d;
        end
    end

    // Next-state and datapath updates; every path that starts a fetch
    // raises 'launch' so request issue is decided in one place below.
    always_comb begin
        state_d      = state_q;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        err_d        = err_q;
        drop_d       = drop_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        cnt_d        = cnt_q;
        stale_d      = stale_q;
        launch       = 1'b0;
        launch_pc    = bus.pc_in;

        if (bus.mem_rsp_valid) stale_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.pc_valid) launch = 1'b1;
            end
            S_REQ: begin
                if (bus.flush) begin
                    drop_d = 1'b1;
                    if (bus.pc_valid) begin
                        pend_d       = bus.pc_in;
                        pend_valid_d = 1'b1;
                    end
                end
                if (bus.mem_req_ready) begin
                    req_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_live || tmo) begin
                    if (tmo) stale_d = 1'b1;
                    if (drop_q || bus.flush) begin
                        drop_d       = 1'b0;
                        pend_valid_d = 1'b0;
                        state_d      = S_IDLE;
                        if (bus.flush && bus.pc_valid) begin
                            launch = 1'b1;
                        end else if (pend_valid_q) begin
                            launch    = 1'b1;
                            launch_pc = pend_q;
                        end
                    end else begin
                        inst_d    = rsp_live ? bus.mem_rsp_data : 32'h0;
                        err_d     = rsp_live ? bus.mem_rsp_err : 1'b1;
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (bus.flush) begin
                        drop_d = 1'b1;
                        if (bus.pc_valid) begin
                            pend_d       = bus.pc_in;
                            pend_valid_d = 1'b1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (bus.flush || bus.inst_ready) begin
                    state_d = S_IDLE;
                    if (bus.pc_valid) launch = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
`ifdef IFU_ALIGN_CHK_EN
            if (launch_pc[1:0] != 2'b00) begin
                inst_d    = '0;
                err_d     = 1'b1;
                inst_pc_d = launch_pc;
                state_d   = S_HOLD;
            end else begin
                req_valid_d = 1'b1;
                req_addr_d  = {launch_pc[ADDR_W-1:2], 2'b00};
                pc_d        = launch_pc;
                state_d     = S_REQ;
            end
`else
            req_valid_d = 1'b1;
            req_addr_d  = {launch_pc[ADDR_W-1:2], 2'b00};
            pc_d        = launch_pc;
            state_d     = S_REQ;
`endif
        end
    end
endmodule
